// File: rtl/img_feat_pkg.sv
// Shared widths, colour codes and state encoding for the image feature
// extractor that feeds the insertion sorter.
package img_feat_pkg;

  localparam int PIX_W  = 8;
  localparam int CNT_W  = 16;
  localparam int FRAC_W = 15;
  localparam int TOT_W  = PIX_W + FRAC_W;
  localparam int IDX_W  = 5;
  localparam int N_IMG  = 32;

  // A channel sum holds up to (2^CNT_W - 1) * (2^PIX_W - 1) without wrapping.
  localparam int SUM_W  = PIX_W + CNT_W;
  localparam int DVD_W  = SUM_W + FRAC_W;

  typedef enum logic [1:0] {
    COL_R    = 2'd0,
    COL_G    = 2'd1,
    COL_B    = 2'd2,
    COL_GREY = 2'd3
  } color_e;

  typedef enum logic [1:0] {
    ACC = 2'd0,
    DIV = 2'd1,
    OUT = 2'd2
  } state_e;

  // Dominant channel; equal sums report grey, otherwise ties favour R over G over B.
  function automatic color_e pick_color(input logic [SUM_W-1:0] r,
                                        input logic [SUM_W-1:0] g,
                                        input logic [SUM_W-1:0] b);
    if (r == g && g == b) return COL_GREY;
    if (r >= g && r >= b) return COL_R;
    if (g >= b)           return COL_G;
    return COL_B;
  endfunction

endpackage

// File: rtl/image_feature_div_seq_div.sv
// Unsigned restoring divider, one quotient bit per cycle, MSB first.
// Caller guarantees the quotient fits Q_W bits (dividend < divisor << Q_W).
module seq_div #(
  parameter int DVD_W = 39,
  parameter int DVS_W = 16,
  parameter int Q_W   = 23
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             start_i,
  input  logic [DVD_W-1:0] dividend_i,
  input  logic [DVS_W-1:0] divisor_i,
  output logic             busy_o,
  output logic             done_o,
  output logic [Q_W-1:0]   quotient_o
);

  localparam int CW = $clog2(Q_W + 1);

  logic [DVS_W-1:0] rem_q, rem_d;
  logic [Q_W-1:0]   work_q, work_d;
  logic [DVS_W-1:0] dvs_q, dvs_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             busy_q, busy_d;
  logic [Q_W-1:0]   quo_q, quo_d;

  logic [DVS_W:0]   trial;
  logic             ge;
  logic [DVS_W-1:0] rem_nx;

  // The partial remainder is always below the divisor, so the shifted trial
  // value needs only one extra bit and the subtraction fits DVS_W bits.
  always_comb begin
    trial  = {rem_q, work_q[Q_W-1]};
    ge     = trial[DVS_W] || (trial[DVS_W-1:0] >= dvs_q);
    rem_nx = ge ? (trial[DVS_W-1:0] - dvs_q) : trial[DVS_W-1:0];
  end

  always_comb begin
    rem_d  = rem_q;
    work_d = work_q;
    dvs_d  = dvs_q;
    cnt_d  = cnt_q;
    busy_d = busy_q;
    quo_d  = quo_q;
    if (start_i) begin
      rem_d  = DVS_W'(dividend_i >> Q_W);
      work_d = dividend_i[Q_W-1:0];
      dvs_d  = divisor_i;
      cnt_d  = CW'(Q_W);
      busy_d = 1'b1;
    end else if (busy_q) begin
      rem_d  = rem_nx;
      work_d = {work_q[Q_W-2:0], ge};
      cnt_d  = cnt_q - CW'(1);
      if (cnt_q == CW'(1)) begin
        busy_d = 1'b0;
        quo_d  = {work_q[Q_W-2:0], ge};
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      rem_q  <= '0;
      work_q <= '0;
      dvs_q  <= '0;
      cnt_q  <= '0;
      busy_q <= 1'b0;
      quo_q  <= '0;
    end else begin
      rem_q  <= rem_d;
      work_q <= work_d;
      dvs_q  <= dvs_d;
      cnt_q  <= cnt_d;
      busy_q <= busy_d;
      quo_q  <= quo_d;
    end
  end

  assign busy_o     = busy_q;
  // Final iteration: the quotient lands on quotient_o at the coming edge.
  assign done_o     = busy_q && (cnt_q == CW'(1));
  assign quotient_o = quo_q;

endmodule

// File: rtl/image_feature_div.sv
// Per-image RGB accumulator: picks the dominant colour at end of image and
// reports its fixed-point mean to the insertion sorter.
//
// state | meaning
// ACC   | accepting pixels, summing channels and counting
// DIV   | dividing selected sum by pixel count, input stalled
// OUT   | one-cycle result pulse, then clear for next image
module image_feature_div
  import img_feat_pkg::*;
(
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             pix_valid_i,
  input  logic             pix_last_i,
  input  logic [PIX_W-1:0] pix_r_i,
  input  logic [PIX_W-1:0] pix_g_i,
  input  logic [PIX_W-1:0] pix_b_i,
  output logic             pix_ready_o,
  output logic [1:0]       color_o,
  output logic [TOT_W-1:0] total_o,
  output logic [IDX_W-1:0] index_o,
  output logic             out_valid_o,
  output logic             frame_done_o,
  output logic             cnt_ovf_o
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [IDX_W-1:0] IDX_MAX = IDX_W'(N_IMG - 1);

  state_e            state_q, state_d;
  logic [SUM_W-1:0]  sum_r_q, sum_r_d;
  logic [SUM_W-1:0]  sum_g_q, sum_g_d;
  logic [SUM_W-1:0]  sum_b_q, sum_b_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [IDX_W-1:0]  idx_q, idx_d;
  logic              ovf_q, ovf_d;
  color_e            sel_col_q, sel_col_d;
  color_e            color_q, color_d;
  logic [IDX_W-1:0]  index_q, index_d;

  logic              div_start;
  logic [SUM_W-1:0]  div_sum;
  logic              div_busy;
  logic              div_done;
  logic [TOT_W-1:0]  div_quo;

  always_comb begin
    state_d   = state_q;
    sum_r_d   = sum_r_q;
    sum_g_d   = sum_g_q;
    sum_b_d   = sum_b_q;
    cnt_d     = cnt_q;
    idx_d     = idx_q;
    ovf_d     = ovf_q;
    sel_col_d = sel_col_q;
    color_d   = color_q;
    index_d   = index_q;
    div_start = 1'b0;
    div_sum   = sum_r_q;

    case (state_q)
      ACC: begin
        if (pix_valid_i) begin
          // A saturated count drops the pixel but still honours pix_last.
          if (cnt_q == CNT_MAX) begin
            ovf_d = 1'b1;
          end else begin
            sum_r_d = sum_r_q + SUM_W'(pix_r_i);
            sum_g_d = sum_g_q + SUM_W'(pix_g_i);
            sum_b_d = sum_b_q + SUM_W'(pix_b_i);
            cnt_d   = cnt_q + CNT_W'(1);
          end
          if (pix_last_i) begin
            state_d   = DIV;
            div_start = 1'b1;
            sel_col_d = pick_color(sum_r_d, sum_g_d, sum_b_d);
          end
        end
      end
      DIV: begin
        if (div_done) begin
          state_d = OUT;
          color_d = sel_col_q;
          index_d = idx_q;
        end else if (!div_busy) begin
          state_d = ACC;
        end
      end
      OUT: begin
        state_d = ACC;
        sum_r_d = '0;
        sum_g_d = '0;
        sum_b_d = '0;
        cnt_d   = '0;
        idx_d   = (idx_q == IDX_MAX) ? '0 : idx_q + IDX_W'(1);
      end
      default: state_d = ACC;
    endcase

    // Grey divides the red sum; all three are equal anyway.
    case (sel_col_d)
      COL_G:   div_sum = sum_g_d;
      COL_B:   div_sum = sum_b_d;
      default: div_sum = sum_r_d;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      state_q   <= ACC;
      sum_r_q   <= '0;
      sum_g_q   <= '0;
      sum_b_q   <= '0;
      cnt_q     <= '0;
      idx_q     <= '0;
      ovf_q     <= 1'b0;
      sel_col_q <= COL_R;
      color_q   <= COL_R;
      index_q   <= '0;
    end else begin
      state_q   <= state_d;
      sum_r_q   <= sum_r_d;
      sum_g_q   <= sum_g_d;
      sum_b_q   <= sum_b_d;
      cnt_q     <= cnt_d;
      idx_q     <= idx_d;
      ovf_q     <= ovf_d;
      sel_col_q <= sel_col_d;
      color_q   <= color_d;
      index_q   <= index_d;
    end
  end

  seq_div #(
    .DVD_W (DVD_W),
    .DVS_W (CNT_W),
    .Q_W   (TOT_W)
  ) u_div (
    .clk_i      (clk_i),
    .rst_i      (rst_i),
    .start_i    (div_start),
    .dividend_i ({div_sum, {FRAC_W{1'b0}}}),
    .divisor_i  (cnt_d),
    .busy_o     (div_busy),
    .done_o     (div_done),
    .quotient_o (div_quo)
  );

  assign pix_ready_o  = (state_q == ACC);
  assign out_valid_o  = (state_q == OUT);
  assign frame_done_o = (state_q == OUT) && (index_q == IDX_MAX);
  assign color_o      = color_q;
  assign total_o      = div_quo;
  assign index_o      = index_q;
  assign cnt_ovf_o    = ovf_q;

endmodule

// File: tb/tb_image_feature_div.sv
// Self-checking bench for image_feature_div: reference model of per-image
// sums and means, per-cycle output compare, plus literal spot checks.
module tb_image_feature_div;
  import img_feat_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic             rst_n = 1'b0;
  logic             pix_valid = 1'b0;
  logic             pix_last = 1'b0;
  logic [PIX_W-1:0] pr = '0, pg = '0, pb = '0;
  logic             pix_ready;
  logic [1:0]       color;
  logic [TOT_W-1:0] total;
  logic [IDX_W-1:0] index;
  logic             out_valid, frame_done, cnt_ovf;

  image_feature_div dut (
    .clk_i        (clk),
    .rst_i        (rst_n),
    .pix_valid_i  (pix_valid),
    .pix_last_i   (pix_last),
    .pix_r_i      (pr),
    .pix_g_i      (pg),
    .pix_b_i      (pb),
    .pix_ready_o  (pix_ready),
    .color_o      (color),
    .total_o      (total),
    .index_o      (index),
    .out_valid_o  (out_valid),
    .frame_done_o (frame_done),
    .cnt_ovf_o    (cnt_ovf)
  );

  int     tests = 0;
  int     fails = 0;
  longint cyc = 0;

  // reference model state
  longint m_sr = 0, m_sg = 0, m_sb = 0, m_cnt = 0;
  int     m_idx = 0;
  bit     m_ovf = 0;
  longint m_out_at = -1;
  int     p_color = 0;
  longint p_total = 0;
  int     e_color = 0, e_index = 0;
  longint e_total = 0;

  // last observed result
  int     n_out = 0;
  int     o_color = 0, o_index = 0;
  longint o_total = 0, o_cyc = 0;
  bit     o_fd = 0;

  task automatic chk(input string name, input longint act, input longint exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  always @(negedge clk) begin
    bit     exp_out;
    longint sel;
    exp_out = (m_out_at == cyc);
    if (exp_out) begin
      e_color = p_color;
      e_total = p_total;
      e_index = m_idx;
    end
    chk("pix_ready",  longint'(pix_ready),  longint'(m_out_at < 0));
    chk("out_valid",  longint'(out_valid),  longint'(exp_out));
    chk("frame_done", longint'(frame_done), longint'(exp_out && m_idx == N_IMG - 1));
    chk("color",      longint'(color),      longint'(e_color));
    chk("total",      longint'(total),      e_total);
    chk("index",      longint'(index),      longint'(e_index));
    chk("cnt_ovf",    longint'(cnt_ovf),    longint'(m_ovf));
    if (out_valid === 1'b1) begin
      n_out++;
      o_color = int'(color);
      o_total = longint'(total);
      o_index = int'(index);
      o_fd    = frame_done;
      o_cyc   = cyc;
    end
    if (!rst_n) begin
      m_sr = 0; m_sg = 0; m_sb = 0; m_cnt = 0;
      m_idx = 0; m_ovf = 0; m_out_at = -1;
      e_color = 0; e_total = 0; e_index = 0;
    end else if (exp_out) begin
      m_sr = 0; m_sg = 0; m_sb = 0; m_cnt = 0;
      m_idx = (m_idx + 1) % N_IMG;
      m_out_at = -1;
    end else if (m_out_at < 0 && pix_valid) begin
      if (m_cnt == 65535) m_ovf = 1;
      else begin
        m_sr += pr; m_sg += pg; m_sb += pb; m_cnt++;
      end
      if (pix_last) begin
        if (m_sr == m_sg && m_sg == m_sb)    p_color = 3;
        else if (m_sr >= m_sg && m_sr >= m_sb) p_color = 0;
        else if (m_sg >= m_sb)               p_color = 1;
        else                                 p_color = 2;
        sel = (p_color == 1) ? m_sg : (p_color == 2) ? m_sb : m_sr;
        p_total  = (sel * 32768) / m_cnt;
        m_out_at = cyc + 24;
      end
    end
    cyc++;
  end

  task automatic drive(input bit v, input bit l, input int r, input int g, input int b);
    pix_valid = v;
    pix_last  = l;
    pr = 8'(r);
    pg = 8'(g);
    pb = 8'(b);
    @(posedge clk);
    #1;
  endtask

  task automatic wait_idle();
    int k = 0;
    while (m_out_at >= 0 && k < 200) begin
      drive(0, 0, 0, 0, 0);
      k++;
    end
    if (k >= 200) begin
      tests++; fails++;
      $display("FAIL idle_timeout: model still busy after %0d cycles, required idle", k);
    end
  endtask

  task automatic send_px(input int r, input int g, input int b, input bit l, output longint at);
    wait_idle();
    at = cyc;
    drive(1, l, r, g, b);
    pix_valid = 0;
    pix_last  = 0;
  endtask

  task automatic wait_out(input int prev);
    int k = 0;
    while (n_out == prev && k < 60) begin
      drive(0, 0, 0, 0, 0);
      k++;
    end
    if (n_out == prev) begin
      tests++; fails++;
      $display("FAIL out_timeout: no out_valid within %0d cycles, required one", k);
    end
  endtask

  task automatic do_reset();
    rst_n = 0;
    drive(0, 0, 0, 0, 0);
    rst_n = 1;
  endtask

  task automatic expect_out(input string name, input int col, input longint tot, input int idx);
    chk({name, "_color"}, longint'(o_color), longint'(col));
    chk({name, "_total"}, o_total, tot);
    chk({name, "_index"}, longint'(o_index), longint'(idx));
  endtask

  initial begin
    longint at;
    int n0, npx, v;
    drive(0, 0, 0, 0, 0);
    drive(0, 0, 0, 0, 0);
    rst_n = 1;
    chk("reset_ready", longint'(pix_ready), 1);
    chk("reset_total", longint'(total), 0);

    n0 = n_out;
    send_px(200, 10, 10, 1, at);
    wait_out(n0);
    expect_out("single", 0, 6553600, 0);
    chk("latency", o_cyc - at, 24);

    n0 = n_out;
    send_px(5, 10, 0, 0, at);
    send_px(5, 20, 0, 0, at);
    send_px(5, 30, 0, 0, at);
    send_px(5, 40, 0, 1, at);
    wait_out(n0);
    expect_out("green4", 1, 819200, 1);

    n0 = n_out;
    for (int i = 0; i < 3; i++) send_px(7, 7, 7, i == 2, at);
    wait_out(n0);
    expect_out("grey", 3, 229376, 2);

    n0 = n_out;
    send_px(50, 50, 10, 1, at);
    wait_out(n0);
    expect_out("tie_rg", 0, 1638400, 3);

    n0 = n_out;
    send_px(1, 0, 0, 0, at);
    send_px(0, 0, 0, 0, at);
    send_px(0, 0, 0, 1, at);
    wait_out(n0);
    expect_out("floor", 0, 10922, 4);

    // pixels presented throughout DIV and OUT must be ignored
    n0 = n_out;
    send_px(100, 0, 0, 1, at);
    for (int i = 0; i < 24; i++) drive(1, 1, 0, 255, 255);
    drive(0, 0, 0, 0, 0);
    chk("div_hold_outs", longint'(n_out - n0), 1);
    expect_out("div_hold", 0, 3276800, 5);
    n0 = n_out;
    send_px(30, 20, 10, 1, at);
    wait_out(n0);
    expect_out("after_hold", 0, 983040, 6);

    // reset in DIV cycle 10 aborts the result
    send_px(9, 9, 200, 1, at);
    for (int i = 0; i < 9; i++) drive(0, 0, 0, 0, 0);
    rst_n = 0;
    drive(0, 0, 0, 0, 0);
    rst_n = 1;
    n0 = n_out;
    for (int i = 0; i < 40; i++) drive(0, 0, 0, 0, 0);
    chk("abort_no_out", longint'(n_out - n0), 0);
    send_px(60, 70, 80, 1, at);
    wait_out(n0);
    expect_out("post_abort", 2, 2621440, 0);

    // index sequencing across a frame boundary
    do_reset();
    for (int i = 0; i < 33; i++) begin
      n0 = n_out;
      send_px(int'($urandom_range(0, 255)), int'($urandom_range(0, 255)),
              int'($urandom_range(0, 255)), 1, at);
      wait_out(n0);
      chk("seq_index", longint'(o_index), longint'(i % N_IMG));
      chk("seq_frame_done", longint'(o_fd), longint'(i == N_IMG - 1));
    end

    // randomized images with gaps and junk during DIV
    for (int img = 0; img < 40; img++) begin
      npx = int'($urandom_range(1, 12));
      for (int p = 0; p < npx; p++) begin
        while ($urandom_range(0, 3) == 0) drive(0, 1, 255, 255, 255);
        v = int'($urandom_range(0, 255));
        if ($urandom_range(0, 4) == 0) send_px(v, v, v, p == npx - 1, at);
        else send_px(int'($urandom_range(0, 255)), int'($urandom_range(0, 255)),
                     int'($urandom_range(0, 255)), p == npx - 1, at);
      end
      for (int j = 0; j < int'($urandom_range(0, 30)); j++)
        drive(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
              int'($urandom_range(0, 255)), int'($urandom_range(0, 255)),
              int'($urandom_range(0, 255)));
      pix_valid = 0;
      pix_last  = 0;
    end
    wait_idle();

    // count saturation: 65536th pixel is dropped, mean over 65535
    do_reset();
    chk("ovf_cleared", longint'(cnt_ovf), 0);
    n0 = n_out;
    for (int i = 0; i < 65535; i++) drive(1, 0, 200, 100, 50);
    drive(1, 1, 0, 255, 255);
    pix_valid = 0;
    pix_last  = 0;
    wait_out(n0);
    expect_out("sat", 0, 6553600, 0);
    chk("sat_ovf", longint'(cnt_ovf), 1);
    do_reset();
    chk("ovf_reset", longint'(cnt_ovf), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
